// File: rtl/clk_ce_manager.sv
// clk_ce_manager: lock-qualified reset sequencer plus fractional CE generators.
// Optional: define CLK_CE_PHASE_ALIGN_EN to add the SYNC phase-align input.
module clk_ce_manager #(
  parameter int          CHANNELS    = 4,
  parameter int          ACC_W       = 24,
  parameter int          LOCK_HOLD   = 1024,
  parameter logic [31:0] DEFAULT_INC = 32'd0,
  localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                REFERENCECLK,
  input  logic                RESET,
  input  logic                PLL_LOCK,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [ACC_W-1:0]    WR_DATA,
`ifdef CLK_CE_PHASE_ALIGN_EN
  input  logic                SYNC,
`endif
  output logic [CHANNELS-1:0] CE,
  output logic                RESET_OUT,
  output logic                LOCKED
);

  localparam int CNT_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [ACC_W-1:0] INC_RST   = DEFAULT_INC[ACC_W-1:0];

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    inc_q [CHANNELS];
  logic [ACC_W-1:0]    inc_d [CHANNELS];
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic                rst_out_q, rst_out_d;
  logic                locked_q, locked_d;
  logic                lock_s;
  logic                sync_clr;
  logic                run_act;

  assign lock_s = sync2_q;

`ifdef CLK_CE_PHASE_ALIGN_EN
  assign sync_clr = SYNC;
`else
  assign sync_clr = 1'b0;
`endif

  // Accumulate only while staying in RUN; lock loss clears on the same edge.
  assign run_act = (state_q == S_RUN) && lock_s;

  // Two-flop synchroniser for the raw PLL lock.
  always_comb begin
    sync1_d = PLL_LOCK;
    sync2_d = sync1_q;
  end

  // Lock qualification FSM with hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT: begin
        cnt_d = '0;
        if (lock_s) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
    rst_out_d = (state_d == S_RUN);
    locked_d  = (state_d == S_RUN);
  end

  // Increment registers; out-of-range channel selects match nothing.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      inc_d[i] = inc_q[i];
      if (WR_EN && (WR_CH == CH_W'(i))) inc_d[i] = WR_DATA;
    end
  end

  // Phase accumulators; carry out becomes the enable pulse.
  always_comb begin
    logic [ACC_W:0] sum;
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = '0;
      ce_d[i]  = 1'b0;
      if (run_act && !sync_clr) begin
        acc_d[i] = sum[ACC_W-1:0];
        ce_d[i]  = sum[ACC_W];
      end
    end
  end

  // State registers.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      ce_q      <= '0;
      rst_out_q <= 1'b0;
      locked_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        inc_q[i] <= INC_RST;
        acc_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      rst_out_q <= rst_out_d;
      locked_q  <= locked_d;
      for (int i = 0; i < CHANNELS; i++) begin
        inc_q[i] <= inc_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign CE        = ce_q;
  assign RESET_OUT = rst_out_q;
  assign LOCKED    = locked_q;

endmodule

// File: tb/tb_clk_ce_manager.sv
// tb_clk_ce_manager: directed vectors for lock qualification, CE rates,
// write boundary, lock loss and reset behaviour (CHANNELS=3, ACC_W=8).
module tb_clk_ce_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] ce;
  logic       rst_out;
  logic       locked;
`ifdef CLK_CE_PHASE_ALIGN_EN
  logic       sync = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic [2:0] exp_ce;
  } vec_t;

  vec_t tbl [17];

  always #5 clk = ~clk;

  clk_ce_manager #(
    .CHANNELS(3),
    .ACC_W(8),
    .LOCK_HOLD(16),
    .DEFAULT_INC(32'd0)
  ) dut (
    .REFERENCECLK(clk),
    .RESET(rst_n),
    .PLL_LOCK(pll),
    .WR_EN(wr_en),
    .WR_CH(wr_ch),
    .WR_DATA(wr_data),
`ifdef CLK_CE_PHASE_ALIGN_EN
    .SYNC(sync),
`endif
    .CE(ce),
    .RESET_OUT(rst_out),
    .LOCKED(locked)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic qualify(input string nm);
    for (int k = 1; k <= 19; k++) begin
      step();
      chk($sformatf("%s_rst_k%0d", nm, k), 32'(rst_out), 32'(k == 19));
      chk($sformatf("%s_lck_k%0d", nm, k), 32'(locked), 32'(k == 19));
      chk($sformatf("%s_ce_k%0d", nm, k), 32'(ce), 32'd0);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_en   = tbl[i].wr_en;
      wr_ch   = tbl[i].wr_ch;
      wr_data = tbl[i].wr_data;
      step();
      wr_en   = 1'b0;
      chk($sformatf("vec%0d_ce", i), 32'(ce), 32'(tbl[i].exp_ce));
    end
  endtask

  initial begin
    int n0, n1, n2;
    // Rate pattern: ch0 inc=64, ch1 inc=96, ch2 inc=0, from first RUN edge.
    tbl[0]  = '{1'b0, 2'd0, 8'd0,   3'b000};
    tbl[1]  = '{1'b0, 2'd0, 8'd0,   3'b000};
    tbl[2]  = '{1'b0, 2'd0, 8'd0,   3'b010};
    tbl[3]  = '{1'b0, 2'd0, 8'd0,   3'b001};
    tbl[4]  = '{1'b0, 2'd0, 8'd0,   3'b000};
    tbl[5]  = '{1'b0, 2'd0, 8'd0,   3'b010};
    tbl[6]  = '{1'b0, 2'd0, 8'd0,   3'b000};
    tbl[7]  = '{1'b0, 2'd0, 8'd0,   3'b011};
    // Write ch0=128 then an out-of-range write (ch 3); accs both start at 0.
    tbl[8]  = '{1'b1, 2'd0, 8'd128, 3'b000};
    tbl[9]  = '{1'b1, 2'd3, 8'd255, 3'b000};
    tbl[10] = '{1'b0, 2'd0, 8'd0,   3'b011};
    tbl[11] = '{1'b0, 2'd0, 8'd0,   3'b000};
    tbl[12] = '{1'b0, 2'd0, 8'd0,   3'b001};
    tbl[13] = '{1'b0, 2'd0, 8'd0,   3'b010};
    tbl[14] = '{1'b0, 2'd0, 8'd0,   3'b001};
    tbl[15] = '{1'b0, 2'd0, 8'd0,   3'b010};
    tbl[16] = '{1'b0, 2'd0, 8'd0,   3'b001};

    repeat (3) step();
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_rstout", 32'(rst_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    step();

    wr(2'd0, 8'd64);
    wr(2'd1, 8'd96);
    wr(2'd2, 8'd0);
    chk("wait_rstout", 32'(rst_out), 32'd0);

    pll = 1'b1;
    qualify("lock");

    run_vecs(0, 7);

    n0 = 0;
    n1 = 0;
    n2 = 0;
    for (int c = 0; c < 256; c++) begin
      step();
      n0 += int'(ce[0]);
      n1 += int'(ce[1]);
      n2 += int'(ce[2]);
    end
    chk("rate_ch0", 32'(n0), 32'd64);
    chk("rate_ch1", 32'(n1), 32'd96);
    chk("rate_ch2", 32'(n2), 32'd0);

    run_vecs(8, 16);

    pll = 1'b0;
    step();
    chk("loss1_rstout", 32'(rst_out), 32'd1);
    chk("loss1_ce", 32'(ce), 32'b000);
    step();
    chk("loss2_rstout", 32'(rst_out), 32'd1);
    chk("loss2_ce", 32'(ce), 32'b011);
    step();
    chk("loss3_rstout", 32'(rst_out), 32'd0);
    chk("loss3_locked", 32'(locked), 32'd0);
    chk("loss3_ce", 32'(ce), 32'b000);
    repeat (3) step();

    pll = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("glitch_hi_k%0d", k), 32'(rst_out), 32'd0);
    end
    pll = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("glitch_lo_k%0d", k), 32'(rst_out), 32'd0);
    end
    pll = 1'b1;
    qualify("glitch");

    step();
    chk("requal_ce1", 32'(ce), 32'b000);
    step();
    chk("requal_ce2", 32'(ce), 32'b001);
    step();
    chk("requal_ce3", 32'(ce), 32'b010);
    step();
    chk("requal_ce4", 32'(ce), 32'b001);

`ifdef CLK_CE_PHASE_ALIGN_EN
    wr(2'd0, 8'd64);
    chk("align_w0_ce", 32'(ce), 32'b000);
    wr(2'd1, 8'd64);
    chk("align_w1_ce", 32'(ce), 32'b010);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("align_sync_ce", 32'(ce), 32'b000);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("align_k%0d", k), 32'(ce),
          (k % 4 == 0) ? 32'b011 : 32'b000);
    end
`endif

    rst_n = 1'b0;
    #1;
    chk("async_rstout", 32'(rst_out), 32'd0);
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_ce", 32'(ce), 32'd0);
    step();
    rst_n = 1'b1;
    qualify("rereset");
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("definc_ce_k%0d", k), 32'(ce), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
